ifetch_prefetch_queue: RTL
==========================

// Module: ifetch_prefetch_queue
// PURPOSE
//  Instruction fetch front end feeding the decode/control stage of the mips core.
//  Issues word fetches to the instruction memory, one request outstanding at a time.
//  Buffers returned {pc, instr} pairs in a small FIFO and presents them with a valid/ready handshake.
//  Accepts a redirect (branch/jump/jr target from npc) that flushes queued and in-flight fetches.
// PARAMETERS
//  DEPTH     4             queue entries; power of 2, minimum 2
//  RESET_PC  32'h0000_3000 first fetch address after reset
// PORTS
//  clk          in   1   single clock; all logic on the rising edge
//  reset        in   1   synchronous, active-low reset (0 = reset)
//  imem_req     out  1   one-cycle fetch request pulse
//  imem_addr    out  32  fetch byte address; bits[1:0] always 2'b00
//  imem_ack     in   1   response strobe, at least 1 cycle after imem_req
//  imem_rdata   in   32  instruction word; valid only when imem_ack=1
//  redirect     in   1   flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch address; bits[1:0] ignored and forced to 0
//  if_valid     out  1   head entry valid
//  if_instr     out  32  head instruction
//  if_pc        out  32  address of the head instruction
//  if_ready     in   1   consumer accepts the head when if_valid & if_ready
// BEHAVIOUR
//  Reset (reset=0 at an edge):
//   - fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0.
//   - Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
//  Request issue:
//   - imem_req=1 for one cycle when outstanding=0, redirect=0, and count<DEPTH.
//   - On that cycle: imem_addr=fetch_pc, outstanding<=1, fetch_pc<=fetch_pc+4.
//   - imem_addr holds its last value between requests.
//   - First request goes out in the first cycle after reset is released.
//  Response:
//   - On imem_ack with discard=0: push {pc_of_request, imem_rdata}; outstanding<=0.
//   - On imem_ack with discard=1: drop the data; outstanding<=0, discard<=0.
//   - imem_ack with outstanding=0 is ignored.
//   - A new request may issue in the same cycle as an ack if space remains after the push.
//  Pop:
//   - Fires when if_valid & if_ready; the head advances.
//   - if_instr/if_pc are registered queue-head values, stable while if_valid & !if_ready.
//  Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
//  Space check: issue only if count + outstanding < DEPTH, so a response can never overflow.
//  Redirect (highest priority):
//   - Queue flushed (count=0) and fetch_pc<=redirect_pc & ~3.
//   - An ack in the same cycle is dropped.
//   - If a request is still in flight after this edge, discard<=1.
//   - No imem_req in the redirect cycle; the next request goes out the following cycle,
//     or after the discarded ack arrives.
//   - A pop in the redirect cycle is ignored for accounting purposes.
//  Latency (no bypass): ack at edge N means if_valid=1 after edge N, with the entry pushed at that edge.
//  Reset mid-operation: every state is cleared; a later imem_ack for a pre-reset request is ignored,
//   because outstanding=0.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//   - When the queue is empty and a non-discarded imem_ack arrives, if_valid=1,
//     if_instr=imem_rdata and if_pc=request pc in the same cycle (combinational path).
//   - If if_ready=1 in that cycle, the word is consumed and not pushed.
//   - Zero-cycle fetch latency.
//  IFQ_BYPASS_EN undefined:
//   - All outputs come from registers; ack-to-if_valid latency is 1 cycle.
// TESTING
//  1. Release reset, memory acks 1 cycle after req, if_ready=1:
//     imem_addr sequence 0x3000, 0x3004, 0x3008; if_pc follows in order with matching instructions.
//  2. if_ready=0, DEPTH=4:
//     exactly 4 requests issue, then imem_req stays 0; raising if_ready resumes fetch at 0x3010.
//  3. Redirect to 0x0000_3047 while a request is in flight:
//     late ack data is dropped, next imem_addr=0x3044, queue empty until the new ack.
//  4. Redirect in the same cycle as an ack and a pop:
//     no push, count=0, next if_pc=redirect target.
//  5. reset=0 for one cycle mid-stream with an ack pending:
//     if_valid=0 and the first fetch is back at 0x3000; the stale ack is ignored.
//  6. Build with IFQ_BYPASS_EN, queue empty, ack at cycle N with if_ready=1:
//     if_valid=1 at cycle N, and count stays 0.

Source files
------------

// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: instruction fetch front end for the mips core.
// Keeps one imem request outstanding at a time. Returned {pc, instr} pairs are buffered in a
// DEPTH-entry FIFO and handed to decode over a valid/ready handshake. A redirect flushes the
// queue and marks any in-flight fetch for discard.
// Optional feature macro IFQ_BYPASS_EN: when the queue is empty, a response is forwarded to the
// consumer in the same cycle. If the consumer takes it, the word is not queued.
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   fetch_pc_q;
  logic [31:0]   addr_q;         // last issued address; also the pc of the in-flight request
  logic          outstanding_q;
  logic          discard_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic          ack_fire;
  logic          ack_data;
  logic          head_valid;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          issue;
  logic [AW:0]   count_after_push;

  // Handshake decode, issue decision and output muxing.
  always_comb begin
    ack_fire   = imem_ack & outstanding_q;
    // Redirect kills a same-cycle response outright.
    ack_data   = ack_fire & ~discard_q & ~redirect;
    head_valid = (count_q != '0);
`ifdef IFQ_BYPASS_EN
    bypass     = ack_data & ~head_valid;
`else
    bypass     = 1'b0;
`endif
    push       = ack_data & ~(bypass & if_ready);
    pop        = head_valid & if_ready & ~redirect;
    // Space test ignores a same-cycle pop so if_ready has no path to imem_req.
    count_after_push = count_q + {{AW{1'b0}}, push};
    issue      = reset & ~redirect & (~outstanding_q | ack_fire) &
                 (count_after_push < DEPTH_CNT);

    imem_req   = issue;
    imem_addr  = issue ? fetch_pc_q : addr_q;
    if_valid   = head_valid | bypass;
    if_instr   = bypass ? imem_rdata : instr_mem_q[rd_ptr_q];
    if_pc      = bypass ? addr_q     : pc_mem_q[rd_ptr_q];
  end

  // Fetch sequencing, in-flight tracking and queue pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      addr_q        <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      if (redirect) begin
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end

      if (issue) begin
        addr_q <= fetch_pc_q;
      end

      if (issue) begin
        outstanding_q <= 1'b1;
      end else if (ack_fire) begin
        outstanding_q <= 1'b0;
      end

      // A fetch still in flight across a redirect belongs to the old path.
      if (redirect) begin
        discard_q <= outstanding_q & ~imem_ack;
      end else if (ack_fire) begin
        discard_q <= 1'b0;
      end

      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
        count_q <= count_after_push - {{AW{1'b0}}, pop};
      end
    end
  end

  // Queue storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= addr_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
